// File: rtl/muldiv_unit_pkg.sv
// Shared types for the M-extension multiply/divide unit: operation codes,
// FSM states and the XLEN-derived word typedefs.
package muldiv_unit_pkg;

  localparam int unsigned XLEN_DEFAULT = 64;
  localparam int unsigned WLEN         = 32;

  typedef logic [WLEN-1:0]           u32;
  typedef logic [XLEN_DEFAULT-1:0]   u64;
  typedef logic [2*XLEN_DEFAULT-1:0] u128;

  typedef enum logic [2:0] {
    MD_MUL    = 3'd0,
    MD_MULH   = 3'd1,
    MD_MULHSU = 3'd2,
    MD_MULHU  = 3'd3,
    MD_DIV    = 3'd4,
    MD_DIVU   = 3'd5,
    MD_REM    = 3'd6,
    MD_REMU   = 3'd7
  } muldiv_op_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_DONE
  } muldiv_state_t;

  function automatic logic op_is_div(input muldiv_op_t op);
    return op inside {MD_DIV, MD_DIVU, MD_REM, MD_REMU};
  endfunction

endpackage

// File: rtl/muldiv_iter.sv
// One radix-2 iteration of the unsigned core: shift-add multiply or
// restoring shift-subtract divide on the {hi, lo} register pair.
module muldiv_iter
  import muldiv_unit_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEFAULT
) (
  input  logic            is_div,
  input  logic [XLEN-1:0] hi,
  input  logic [XLEN-1:0] lo,
  input  logic [XLEN-1:0] m,
  output logic [XLEN-1:0] hi_nx,
  output logic [XLEN-1:0] lo_nx
);

  logic [XLEN:0] sum;
  logic [XLEN:0] addend;
  logic [XLEN:0] shifted;
  logic [XLEN:0] trial;

  always_comb begin
    sum     = {1'b0, hi} + {1'b0, m};
    addend  = lo[0] ? sum : {1'b0, hi};
    shifted = {hi, lo[XLEN-1]};
    // Remainder stays below the divisor, so the top bit of trial is a clean borrow flag.
    trial   = shifted - {1'b0, m};
    if (is_div) begin
      hi_nx = trial[XLEN] ? shifted[XLEN-1:0] : trial[XLEN-1:0];
      lo_nx = {lo[XLEN-2:0], ~trial[XLEN]};
    end else begin
      hi_nx = addend[XLEN:1];
      lo_nx = {addend[0], lo[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV64 M-extension unit: FSM, operand sign/W handling and result
// fix-up around the muldiv_iter radix-2 core.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            valid,
  input  logic [2:0]      op,
  input  logic            word,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            stall,
  input  logic            flush,
  output logic            ok,
  output logic [XLEN-1:0] result
);

  localparam int unsigned CW = $clog2(XLEN + 1);
  localparam int unsigned HW = WLEN;

  function automatic logic [XLEN-1:0] sext_w(input logic [HW-1:0] x);
    return {{(XLEN-HW){x[HW-1]}}, x};
  endfunction

  muldiv_state_t   state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] hi_q, hi_d, lo_q, lo_d, m_q, m_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            div_q, div_d, word_q, word_d, neg_q, neg_d;
  logic            sel_q, sel_d;  // mul: return high half; div: return remainder

  logic [XLEN-1:0] hi_nx, lo_nx;

  muldiv_iter #(.XLEN(XLEN)) u_iter (
    .is_div (div_q),
    .hi     (hi_q),
    .lo     (lo_q),
    .m      (m_q),
    .hi_nx  (hi_nx),
    .lo_nx  (lo_nx)
  );

  muldiv_op_t      op_e;
  logic            req_div, req_mulw, sgn_a, sgn_b, sa, sb, b_zero, ovf;
  logic [XLEN-1:0] mag_a, mag_b, fast_res;
  logic [HW-1:0]   mag_a_w, mag_b_w;

  always_comb begin
    op_e     = muldiv_op_t'(op);
    req_div  = op_is_div(op_e);
    req_mulw = word & ~req_div;
    sgn_a    = ~req_mulw & (op_e inside {MD_MULH, MD_MULHSU, MD_DIV, MD_REM});
    sgn_b    = ~req_mulw & (op_e inside {MD_MULH, MD_DIV, MD_REM});
    sa       = sgn_a & (word ? a[HW-1] : a[XLEN-1]);
    sb       = sgn_b & (word ? b[HW-1] : b[XLEN-1]);
    mag_a    = sa ? -a : a;
    mag_b    = sb ? -b : b;
    mag_a_w  = sa ? -a[HW-1:0] : a[HW-1:0];
    mag_b_w  = sb ? -b[HW-1:0] : b[HW-1:0];
    b_zero   = word ? (b[HW-1:0] == '0) : (b == '0);
    ovf      = (op_e inside {MD_DIV, MD_REM}) &
               (word ? ((a[HW-1:0] == {1'b1, {(HW-1){1'b0}}}) && (b[HW-1:0] == '1))
                     : ((a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1)));
    fast_res = '0;
    if (b_zero) begin
      if (op_e inside {MD_DIV, MD_DIVU}) fast_res = '1;
      else                               fast_res = word ? sext_w(a[HW-1:0]) : a;
    end else if (op_e == MD_DIV) begin
      fast_res = word ? sext_w(a[HW-1:0]) : a;
    end
  end

  // Final sign fix-up uses the iterator's outputs so the result is ready on DONE entry.
  logic [2*XLEN-1:0] prod, prod_s;
  logic [XLEN-1:0]   dv, dv_s, done_res;
  logic [HW-1:0]     dv_w, dv_ws;

  always_comb begin
    prod   = {hi_nx, lo_nx};
    prod_s = neg_q ? -prod : prod;
    dv     = sel_q ? hi_nx : lo_nx;
    dv_s   = neg_q ? -dv : dv;
    dv_w   = dv[HW-1:0];
    dv_ws  = neg_q ? -dv_w : dv_w;
    if (!div_q) begin
      if (word_q)     done_res = sext_w(lo_nx[XLEN-1 -: HW]);
      else if (sel_q) done_res = prod_s[2*XLEN-1:XLEN];
      else            done_res = prod_s[XLEN-1:0];
    end else begin
      done_res = word_q ? sext_w(dv_ws) : dv_s;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    m_d      = m_q;
    result_d = result_q;
    div_d    = div_q;
    word_d   = word_q;
    neg_d    = neg_q;
    sel_d    = sel_q;
    case (state_q)
      ST_IDLE: begin
        if (valid) begin
          div_d  = req_div;
          word_d = word;
          if (req_div && (b_zero || ovf)) begin
            state_d  = ST_DONE;
            result_d = fast_res;
          end else begin
            state_d  = ST_BUSY;
            cnt_d    = word ? CW'(HW) : CW'(XLEN);
            result_d = '0;
            neg_d    = (op_e == MD_REM) ? sa : (sa ^ sb);
            sel_d    = req_div ? (op_e inside {MD_REM, MD_REMU}) : ((op_e != MD_MUL) && !word);
            hi_d     = '0;
            if (!word)        lo_d = mag_a;
            else if (req_div) lo_d = {mag_a_w, {(XLEN-HW){1'b0}}};
            else              lo_d = {{(XLEN-HW){1'b0}}, mag_a_w};
            m_d      = word ? {{(XLEN-HW){1'b0}}, mag_b_w} : mag_b;
          end
        end
      end
      ST_BUSY: begin
        hi_d  = hi_nx;
        lo_d  = lo_nx;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          state_d  = ST_DONE;
          result_d = done_res;
        end
      end
      ST_DONE: begin
        if (!stall) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (flush) begin
      state_d  = ST_IDLE;
      cnt_d    = '0;
      result_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      m_q      <= '0;
      result_q <= '0;
      div_q    <= 1'b0;
      word_q   <= 1'b0;
      neg_q    <= 1'b0;
      sel_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      m_q      <= m_d;
      result_q <= result_d;
      div_q    <= div_d;
      word_q   <= word_d;
      neg_q    <= neg_d;
      sel_q    <= sel_d;
    end
  end

  always_comb begin
    case (state_q)
      ST_BUSY: ok = 1'b0;
      ST_IDLE: ok = ~valid;
      default: ok = 1'b1;
    endcase
  end

  assign result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed vectors, hand-written
// stall/flush/reset sequences and random ops against an arithmetic model.
module tb_muldiv_unit;
  import muldiv_unit_pkg::*;

  logic       clk, rst, valid, word, stall, flush, ok;
  logic [2:0] op;
  u64         a, b, result;

  int checks = 0;
  int errors = 0;

  muldiv_unit #(.XLEN(64)) dut (
    .clk    (clk),
    .reset  (rst),
    .valid  (valid),
    .op     (op),
    .word   (word),
    .a      (a),
    .b      (b),
    .stall  (stall),
    .flush  (flush),
    .ok     (ok),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not end, got time %0t required end before it", $time);
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic u64 ref_res(input logic [2:0] o, input logic w, input u64 x, input u64 y);
    logic signed [127:0] ps;
    logic [127:0]        pu;
    logic signed [63:0]  xs, ys;
    logic signed [31:0]  xw, yw;
    logic [31:0]         r32;
    xs = x; ys = y; xw = x[31:0]; yw = y[31:0];
    r32 = '0;
    if (w) begin
      case (muldiv_op_t'(o))
        MD_DIV:  if (yw == 0) r32 = '1;
                 else if (xw == 32'sh8000_0000 && yw == -1) r32 = xw;
                 else r32 = xw / yw;
        MD_DIVU: r32 = (y[31:0] == 0) ? '1 : x[31:0] / y[31:0];
        MD_REM:  if (yw == 0) r32 = xw;
                 else if (xw == 32'sh8000_0000 && yw == -1) r32 = '0;
                 else r32 = xw % yw;
        MD_REMU: r32 = (y[31:0] == 0) ? x[31:0] : x[31:0] % y[31:0];
        default: r32 = x[31:0] * y[31:0];
      endcase
      return {{32{r32[31]}}, r32};
    end
    case (muldiv_op_t'(o))
      MD_MUL:    return x * y;
      MD_MULH:   begin ps = $signed({{64{x[63]}}, x}) * $signed({{64{y[63]}}, y}); return ps[127:64]; end
      MD_MULHSU: begin ps = $signed({{64{x[63]}}, x}) * $signed({64'd0, y});       return ps[127:64]; end
      MD_MULHU:  begin pu = {64'd0, x} * {64'd0, y};                                 return pu[127:64]; end
      MD_DIV:    if (ys == 0) return '1;
                 else if (x == 64'h8000_0000_0000_0000 && ys == -1) return x;
                 else return xs / ys;
      MD_DIVU:   return (y == 0) ? '1 : x / y;
      MD_REM:    if (ys == 0) return x;
                 else if (x == 64'h8000_0000_0000_0000 && ys == -1) return '0;
                 else return xs % ys;
      default:   return (y == 0) ? x : x % y;
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] o, input logic w, input u64 x, input u64 y);
    logic is_div, signed_div, zero, ov;
    is_div     = (o >= 3'd4);
    signed_div = (o == 3'd4) || (o == 3'd6);
    zero       = w ? (y[31:0] == 0) : (y == 0);
    ov         = w ? (x[31:0] == 32'h8000_0000 && y[31:0] == 32'hFFFF_FFFF)
                   : (x == 64'h8000_0000_0000_0000 && y == '1);
    if (is_div && (zero || (signed_div && ov))) return 1;
    return w ? 33 : 65;
  endfunction

  function automatic u64 rand_operand();
    case ($urandom_range(0, 6))
      0: return {$urandom, $urandom};
      1: return 64'($urandom_range(0, 20));
      2: return '1;
      3: return 64'h8000_0000_0000_0000;
      4: return '0;
      5: return -64'($urandom_range(1, 20));
      default: return {$urandom, 32'h8000_0000};
    endcase
  endfunction

  task automatic wait_ok(output int cyc);
    cyc = 0;
    while (ok !== 1'b1 && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic run_op(input logic [2:0] o, input logic w, input u64 x, input u64 y,
                        input int exp_lat, input u64 exp_res, input string name);
    int lat;
    op = o; word = w; a = x; b = y; valid = 1'b1;
    #1;
    wait_ok(lat);
    chk({name, " latency"}, 64'(lat), 64'(exp_lat));
    chk({name, " result"}, result, exp_res);
    valid = 1'b0;
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic [2:0] o;
    logic       w;
    u64         x, y, res;
    int         lat;
    string      name;
  } vec_t;

  vec_t vecs[13];

  initial begin
    int lat;
    logic [2:0] ro;
    logic       rw;
    u64         rx, ry;

    vecs[0]  = '{MD_MUL,    1'b0, 64'd3, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFA, 65, "mul_neg2"};
    vecs[1]  = '{MD_DIV,    1'b0, 64'd7, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1, "div_by0"};
    vecs[2]  = '{MD_REM,    1'b0, 64'd7, 64'd0, 64'd7, 1, "rem_by0"};
    vecs[3]  = '{MD_DIV,    1'b0, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 1, "div_ovf"};
    vecs[4]  = '{MD_REM,    1'b0, 64'h8000_0000_0000_0000, '1, 64'd0, 1, "rem_ovf"};
    vecs[5]  = '{MD_MULHU,  1'b0, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, 65, "mulhu_ones"};
    vecs[6]  = '{MD_DIV,    1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 33, "divw"};
    vecs[7]  = '{MD_REMU,   1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2, 64'd1, 33, "remuw"};
    vecs[8]  = '{MD_MULH,   1'b0, '1, '1, 64'd0, 65, "mulh_m1"};
    vecs[9]  = '{MD_MULHSU, 1'b0, '1, '1, 64'hFFFF_FFFF_FFFF_FFFF, 65, "mulhsu"};
    vecs[10] = '{MD_DIV,    1'b0, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 64'hFFFF_FFFF_FFFF_FFFA, 65, "div_neg"};
    vecs[11] = '{MD_REM,    1'b0, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 64'hFFFF_FFFF_FFFF_FFFE, 65, "rem_neg"};
    vecs[12] = '{MD_MULH,   1'b1, 64'h0000_0000_7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 33, "mulh_as_mulw"};

    rst = 1'b1; valid = 1'b0; op = '0; word = 1'b0; a = '0; b = '0; stall = 1'b0; flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset ok idle", 64'(ok), 64'd1);
    chk("reset result", result, 64'd0);
    valid = 1'b1;
    #1;
    chk("reset ok follows valid", 64'(ok), 64'd0);
    valid = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 13; i++)
      run_op(vecs[i].o, vecs[i].w, vecs[i].x, vecs[i].y, vecs[i].lat, vecs[i].res, vecs[i].name);

    // DONE stall hold, operand changes ignored while busy
    op = MD_MUL; word = 1'b0; a = 64'd5; b = 64'd6; valid = 1'b1;
    #1;
    @(posedge clk); #1;
    a = {$urandom, $urandom}; b = {$urandom, $urandom};
    wait_ok(lat);
    chk("stall latency", 64'(lat + 1), 64'd65);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall ok held", 64'(ok), 64'd1);
      chk("stall result held", result, 64'd30);
      @(posedge clk); #1;
    end
    stall = 1'b0; valid = 1'b0;
    @(posedge clk); #1;
    op = MD_DIVU; a = 64'd100; b = 64'd7; valid = 1'b1;
    #1;
    chk("idle after stall", 64'(ok), 64'd0);
    wait_ok(lat);
    chk("post stall divu latency", 64'(lat), 64'd65);
    chk("post stall divu result", result, 64'd14);

    // valid held through DONE must not restart directly
    valid = 1'b1; op = MD_MUL; a = 64'd7; b = 64'd9;
    @(posedge clk); #1;
    wait_ok(lat);
    chk("held valid result", result, 64'd63);
    @(posedge clk); #1;
    chk("no restart from done", 64'(ok), 64'd0);
    wait_ok(lat);
    chk("restart latency from idle", 64'(lat), 64'd65);
    valid = 1'b0;
    @(posedge clk); #1;

    // flush mid-busy
    op = MD_DIV; word = 1'b0; a = 64'd100; b = 64'd7; valid = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("busy at cycle 10", 64'(ok), 64'd0);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; valid = 1'b0;
    #1;
    chk("flush ok", 64'(ok), 64'd1);
    chk("flush result cleared", result, 64'd0);
    run_op(MD_DIV, 1'b0, 64'd100, 64'd7, 65, 64'd14, "after flush");

    // reset mid-busy
    op = MD_MUL; a = 64'h1234; b = 64'h5678; valid = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    rst = 1'b1; valid = 1'b0;
    #1;
    chk("async reset ok", 64'(ok), 64'd1);
    chk("async reset result", result, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    run_op(MD_MUL, 1'b0, 64'd5, 64'd6, 65, 64'd30, "mul after reset");

    for (int i = 0; i < 40; i++) begin
      ro = 3'($urandom_range(0, 7));
      rw = 1'($urandom_range(0, 1));
      rx = rand_operand();
      ry = rand_operand();
      run_op(ro, rw, rx, ry, ref_lat(ro, rw, rx, ry), ref_res(ro, rw, rx, ry),
             $sformatf("rand op%0d w%0d a=%h b=%h", ro, rw, rx, ry));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The block SHALL have one parameter: XLEN, default 64, datapath and operand width.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 valid  input  1  Execute holds an M-extension instruction; held stable while Execute is stalled.
REQ-005 op  input  3  muldiv_op_t: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
REQ-006 word  input  1  RV64 W-variant: operate on the low 32 bits and sign-extend the result.
REQ-007 a, b  input  XLEN each  rs1 and rs2 operand values, already forwarded.
REQ-008 stall  input  1  Execute stage stall (stallE); instruction stays in Execute.
REQ-009 flush  input  1  Execute stage flush (flushE); discards the instruction.
REQ-010 ok  output  1  mult_ok to the hazard unit; low while a result is pending.
REQ-011 result  output  XLEN  operation result; valid when ok=1 and valid=1.

Function
REQ-012 States SHALL be IDLE, BUSY and DONE.
REQ-013 IDLE with valid=1 SHALL enter BUSY next cycle, iteration counter = XLEN (64 cycles), or 32 when word=1.
REQ-014 Exception: DIV/REM with b=0 or signed overflow SHALL go IDLE->DONE in one cycle.
REQ-015 BUSY SHALL perform one radix-2 step per cycle, decrement the counter, and enter DONE when the counter reaches 0.
REQ-016 DONE SHALL hold result while stall=1 and return to IDLE when stall=0.
REQ-017 ok SHALL be combinational: 0 in BUSY, 0 in IDLE when valid=1, and 1 otherwise (IDLE with valid=0, or DONE).
REQ-018 Latency SHALL be: request at cycle 0, ok=1 at cycle XLEN+1 (65), or 33 for W-ops; exception ops give ok=1 at cycle 1.
REQ-019 Signed ops SHALL use magnitudes on an unsigned core and fix signs at DONE entry. MULHSU: a signed, b unsigned.
REQ-020 MUL SHALL return the low XLEN bits; MULH, MULHSU and MULHU SHALL return the high XLEN bits of the 2*XLEN product.
REQ-021 Divide by zero SHALL give quotient all-ones and remainder = a (W-ops: low 32 bits of a, sign-extended).
REQ-022 Signed overflow (most-negative / -1) SHALL give quotient = a and remainder 0; the 32-bit analogue applies for W-ops.
REQ-023 word=1 with op MULH, MULHSU or MULHU SHALL behave as MULW.
REQ-024 Operands SHALL be captured at IDLE->BUSY; a and b changes during BUSY or DONE SHALL be ignored.
REQ-025 flush=1 in any state SHALL force IDLE next cycle, with no result retained. flush has priority over stall and over a new request.
REQ-026 When stall=0 in DONE and valid is still asserted the same cycle, the block SHALL NOT restart; the next request is taken only from IDLE.

Reset
REQ-027 Reset asserted SHALL immediately force IDLE, counter 0 and internal result/partial registers 0. ok then equals ~valid and result reads 0.
REQ-028 Reset mid-BUSY SHALL abandon the operation with no residual effect after deassertion.

Structure
REQ-029 muldiv_op_t, XLEN-derived typedefs (u64 and related) and the state enum SHALL live in the shared common package.
REQ-030 The shift-subtract/shift-add iteration datapath SHALL be one sub-module, muldiv_iter. The FSM, sign handling and W-handling SHALL stay in muldiv_unit.
REQ-031 Implementation size SHALL be 120-400 lines of RTL; no multi-cycle combinational paths; one iteration per clock.

Verification
REQ-032 MUL a=3, b=0xFFFF_FFFF_FFFF_FFFE -> ok=0 for cycles 0-64, ok=1 at cycle 65, result 0xFFFF_FFFF_FFFF_FFFA.
REQ-033 DIV a=7, b=0 -> ok=1 at cycle 1, result 0xFFFF_FFFF_FFFF_FFFF; REM a=7, b=0 -> result 7.
REQ-034 DIV a=0x8000_0000_0000_0000, b=-1 -> result 0x8000_0000_0000_0000; REM same operands -> result 0. MULHU a=b=all-ones -> result 0xFFFF_FFFF_FFFF_FFFE.
REQ-035 DIVW a=0x0000_0000_FFFF_FFF9, b=2 -> ok=1 at cycle 33, result 0xFFFF_FFFF_FFFF_FFFD; REMUW same operands -> result 1.
REQ-036 stall=1 for 3 cycles in DONE -> result and ok=1 stable over those cycles, then IDLE.
REQ-037 flush at BUSY cycle 10 -> IDLE next cycle, ok=1 with valid=0. reset pulse at BUSY cycle 20 -> immediate IDLE; a fresh MUL 5*6 after reset -> result 30.
